// File: rtl/ps2_mouse_rx_pkg.sv
// Shared definitions for the PS/2 mouse receiver and the downstream AMX stage.
package ps2_mouse_rx_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Status byte bit that is always 1 in a well-formed first packet byte
    localparam int unsigned PS2_STATUS_SYNC_BIT = 3;

    // Packet byte indices
    localparam logic [1:0] IDX_STATUS = 2'd0;
    localparam logic [1:0] IDX_X      = 2'd1;
    localparam logic [1:0] IDX_Y      = 2'd2;

    // ps2_mouse bus field offsets
    localparam int unsigned STAT_LSB = 0;
    localparam int unsigned X_LSB    = 8;
    localparam int unsigned Y_LSB    = 16;
    localparam int unsigned TOGGLE   = 24;

    // True when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a persistence filter for one PS/2 line.
// The filtered level only follows the line after FILTER_LEN consecutive
// synchronised samples that all differ from the current filtered level.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_raw,
    output logic line_filt
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Bring the asynchronous line into the clock domain; idle level is 1
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive differing samples; any agreeing sample restarts the run
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync2_q == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign line_filt = filt_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: frames bytes off the wire, assembles
// 3-byte movement packets and publishes them with a per-packet toggle bit.
module ps2_mouse_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 6400
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic        pkt_err
);

    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    logic clk_f;
    logic data_f;
    logic clk_f_q;
    logic fall;

    rx_state_e state_q, state_d;

    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [1:0]     idx_q;
    logic [7:0]     stat_q;
    logic [7:0]     x_q;
    logic [TCW-1:0] to_cnt_q;
    logic [24:0]    mouse_q;
    logic           err_q;

    // FSM-decoded actions
    logic start_ok;
    logic start_err;
    logic shift_en;
    logic par_cap;
    logic frame_end;

    logic frame_ok;
    logic byte_valid;
    logic frame_bad;
    logic resync_err;
    logic pkt_done;
    logic to_active;
    logic timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk      (clk_sys),
        .reset    (reset),
        .line_raw (ps2_clk),
        .line_filt(clk_f)
    );

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_data_filter (
        .clk      (clk_sys),
        .reset    (reset),
        .line_raw (ps2_data),
        .line_filt(data_f)
    );

    assign fall = clk_f_q & ~clk_f;

    // Frame FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state; timeout and fall never coincide (fall wins upstream)
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            unique case (state_q)
                RX_IDLE:   if (!data_f) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: per-state action strobes qualified by the fall edge
    always_comb begin
        start_ok  = 1'b0;
        start_err = 1'b0;
        shift_en  = 1'b0;
        par_cap   = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                start_ok  = fall & ~data_f;
                start_err = fall & data_f;
            end
            RX_DATA:   shift_en  = fall;
            RX_PARITY: par_cap   = fall;
            RX_STOP:   frame_end = fall;
            default:   ;
        endcase
    end

    // Byte qualification, packet decisions and timeout detection
    always_comb begin
        frame_ok   = data_f & odd_parity_ok(shift_q, par_q);
        byte_valid = frame_end & frame_ok;
        frame_bad  = frame_end & ~frame_ok;
        resync_err = byte_valid && (idx_q == IDX_STATUS) && !shift_q[PS2_STATUS_SYNC_BIT];
        pkt_done   = byte_valid && (idx_q == IDX_Y);
        to_active  = (state_q != RX_IDLE) || (idx_q != IDX_STATUS);
        timeout    = to_active && !fall && (to_cnt_q == TCW'(TIMEOUT_CYC - 1));
    end

    // Edge history, frame datapath and bit counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_f_q   <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            clk_f_q <= clk_f;
            if (start_ok) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            // LSB arrives first, so shift in from the top
            if (shift_en) shift_q <= {data_f, shift_q[7:1]};
            if (par_cap) par_q <= data_f;
        end
    end

    // Packet assembly and publication; the toggle flips with every new packet
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idx_q   <= IDX_STATUS;
            stat_q  <= '0;
            x_q     <= '0;
            mouse_q <= '0;
        end else if (timeout || frame_bad) begin
            idx_q <= IDX_STATUS;
        end else if (byte_valid) begin
            unique case (idx_q)
                IDX_STATUS: begin
                    if (shift_q[PS2_STATUS_SYNC_BIT]) begin
                        stat_q <= shift_q;
                        idx_q  <= IDX_X;
                    end
                end
                IDX_X: begin
                    x_q   <= shift_q;
                    idx_q <= IDX_Y;
                end
                IDX_Y: begin
                    mouse_q[STAT_LSB +: 8] <= stat_q;
                    mouse_q[X_LSB +: 8]    <= x_q;
                    mouse_q[Y_LSB +: 8]    <= shift_q;
                    mouse_q[TOGGLE]        <= ~mouse_q[TOGGLE];
                    idx_q                  <= IDX_STATUS;
                end
                default: idx_q <= IDX_STATUS;
            endcase
        end
    end

    // Inactivity counter: cleared by every fall, idle when nothing is pending
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (fall || !to_active || timeout) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TCW'(1);
        end
    end

    // Single error pulse covering every discard reason
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_err | frame_bad | resync_err | timeout;
        end
    end

    assign ps2_mouse = mouse_q;
    assign pkt_err   = err_q;

    logic unused_pkt_done;
    assign unused_pkt_done = pkt_done;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: drives PS/2 frames and compares the
// bus and error pulse every cycle against a packet-level model.
module tb_ps2_mouse_rx;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TOUT = 6400;
    localparam int H   = 20;              // half PS/2 bit period in clk_sys cycles
    localparam int LAT = 2 + FLEN + 1;    // sync + filter + registered output

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [24:0] ps2_mouse;
    logic        pkt_err;

    ps2_mouse_rx #(
        .FILTER_LEN (FLEN),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_mouse(ps2_mouse),
        .pkt_err  (pkt_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct { int due; logic [24:0] val; } upd_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } lit_t;

    // Written by the stimulus process only
    upd_t        upd_q[$];
    int          err_q[$];
    lit_t        lit_q[$];
    int          to_due = -1;
    int          m_idx  = 0;
    logic        m_tog  = 1'b0;
    logic [7:0]  m_stat = 8'h00;
    logic [7:0]  m_x    = 8'h00;
    bit          chk_en = 1'b0;

    // Written by the compare process only
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          err_seen  = 0;
    int          u_rd = 0, e_rd = 0, l_rd = 0;
    logic [24:0] exp_mouse = '0;
    logic        cmp_err;

    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Compare process: model outputs versus DUT on every cycle
    initial forever begin
        @(negedge clk_sys);
        while (u_rd < upd_q.size() && upd_q[u_rd].due <= cyc) begin
            exp_mouse = upd_q[u_rd].val;
            u_rd++;
        end
        cmp_err = 1'b0;
        while (e_rd < err_q.size() && err_q[e_rd] <= cyc) begin
            if (err_q[e_rd] == cyc) cmp_err = 1'b1;
            e_rd++;
        end
        if (to_due == cyc) cmp_err = 1'b1;
        if (pkt_err === 1'b1) err_seen++;
        if (chk_en) begin
            do_check("ps2_mouse", {7'b0, ps2_mouse}, {7'b0, exp_mouse});
            do_check("pkt_err", {31'b0, pkt_err}, {31'b0, cmp_err});
        end
        while (l_rd < lit_q.size()) begin
            do_check(lit_q[l_rd].name, lit_q[l_rd].act, lit_q[l_rd].exp);
            l_rd++;
        end
    end

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_q.push_back('{n, a, e});
    endtask

    // A pending inactivity timeout fires unless this fall's strobe lands first
    task automatic model_pre_fall(input int due);
        if (to_due >= 0 && to_due < due) m_idx = 0;
    endtask

    // Packet-level model of one completed frame
    task automatic model_frame(input logic [7:0] b, input bit ok, input int due);
        model_pre_fall(due);
        if (!ok) begin
            err_q.push_back(due);
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (b[3]) begin
                m_stat = b;
                m_idx  = 1;
            end else begin
                err_q.push_back(due);
            end
        end else if (m_idx == 1) begin
            m_x   = b;
            m_idx = 2;
        end else begin
            m_tog = ~m_tog;
            upd_q.push_back('{due, {m_tog, b, m_x, m_stat}});
            m_idx = 0;
        end
        to_due = (m_idx != 0) ? due + TOUT : -1;
    endtask

    // Drive nfall bits of a frame (11 = full); optional short low glitches
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nfall,
                              input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfall; i++) begin
            ps2_data = bits[i];
            if (glitch && i >= 3 && i <= 6) begin
                repeat (12) @(negedge clk_sys);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk_sys);
                ps2_clk = 1'b1;
                repeat (H - 15) @(negedge clk_sys);
            end else begin
                repeat (H) @(negedge clk_sys);
            end
            ps2_clk = 1'b0;
            if (i == 10) begin
                model_frame(b, !bad_par, cyc + LAT);
            end else begin
                model_pre_fall(cyc + LAT);
                to_due = cyc + LAT + TOUT;
            end
            repeat (H) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk_sys);
    endtask

    task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y,
                            input bit glitch);
        send_frame(s, 1'b0, 11, glitch);
        send_frame(x, 1'b0, 11, glitch);
        send_frame(y, 1'b0, 11, glitch);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        upd_q.push_back('{cyc + 1, 25'h0});
        m_idx  = 0;
        m_tog  = 1'b0;
        to_due = -1;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    int e0;

    initial begin
        repeat (3) @(negedge clk_sys);
        lit("reset ps2_mouse", {7'b0, ps2_mouse}, 32'h0);
        lit("reset pkt_err", {31'b0, pkt_err}, 32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(negedge clk_sys);

        // Clean packet
        e0 = err_seen;
        send_pkt(8'h09, 8'h05, 8'hFB, 1'b0);
        lit("clean pkt value", {7'b0, ps2_mouse}, 32'h01FB0509);
        lit("clean pkt errors", err_seen - e0, 32'd0);

        // Bad parity on X byte, then a good packet
        e0 = err_seen;
        send_frame(8'h09, 1'b0, 11, 1'b0);
        send_frame(8'h05, 1'b1, 11, 1'b0);
        send_pkt(8'h08, 8'h01, 8'h02, 1'b0);
        lit("parity pkt value", {7'b0, ps2_mouse}, 32'h00020108);
        lit("parity pkt errors", err_seen - e0, 32'd1);

        // Status byte without sync bit is discarded
        e0 = err_seen;
        send_frame(8'h00, 1'b0, 11, 1'b0);
        send_pkt(8'h18, 8'hFF, 8'h01, 1'b0);
        lit("resync pkt value", {7'b0, ps2_mouse}, 32'h0101FF18);
        lit("resync pkt errors", err_seen - e0, 32'd1);

        // Partial packet abandoned by the inactivity timeout
        e0 = err_seen;
        send_frame(8'h08, 1'b0, 11, 1'b0);
        send_frame(8'h10, 1'b0, 11, 1'b0);
        lit("partial holds value", {7'b0, ps2_mouse}, 32'h0101FF18);
        repeat (TOUT + 200) @(negedge clk_sys);
        send_pkt(8'h28, 8'h03, 8'h04, 1'b0);
        lit("timeout pkt value", {7'b0, ps2_mouse}, 32'h00040328);
        lit("timeout pkt errors", err_seen - e0, 32'd1);

        // Short clock glitches must not shift extra bits
        e0 = err_seen;
        send_pkt(8'h19, 8'h22, 8'h33, 1'b1);
        lit("glitch pkt value", {7'b0, ps2_mouse}, 32'h01332219);
        lit("glitch pkt errors", err_seen - e0, 32'd0);

        // Reset in the middle of the X byte
        send_frame(8'h09, 1'b0, 11, 1'b0);
        send_frame(8'h05, 1'b0, 6, 1'b0);
        do_reset();
        lit("post reset value", {7'b0, ps2_mouse}, 32'h0);
        e0 = err_seen;
        send_pkt(8'h09, 8'h01, 8'h01, 1'b0);
        lit("after reset pkt value", {7'b0, ps2_mouse}, 32'h01010109);
        lit("after reset pkt errors", err_seen - e0, 32'd0);

        repeat (3) @(negedge clk_sys);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
